// File: rtl/calc_entry_fsm.sv
// rtl/calc_entry_fsm.sv - operand/opcode entry sequencer with ALU start/done handshake and timeout
module calc_entry_fsm #(
  parameter int BITS    = 8,
  parameter int NUM_OPS = 2,
  parameter int OP_W    = 3,
  parameter int DIGITS  = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    next,
  input  logic                    undo,
  input  logic [BITS-1:0]         SW,
  input  logic [BITS-1:0]         alu_result,
  input  logic                    alu_invalid,
  input  logic                    alu_done,
  output logic [NUM_OPS*BITS-1:0] operands,
  output logic [OP_W-1:0]         opcode,
  output logic                    alu_start,
  output logic [BITS-1:0]         num_salida,
  output logic [7:0]              anodoIn,
  output logic [3:0]              op_number,
  output logic [1:0]              LED_RG
);

  localparam int IW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OPS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
  localparam logic [7:0]    DIG_MASK = 8'((1 << DIGITS) - 1);

  typedef enum logic [1:0] {
    WAIT_OPERAND,
    WAIT_OPCODE,
    COMPUTE,
    SHOW_RESULT
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_OPS*BITS-1:0] operands_q, operands_d;
  logic [OP_W-1:0]         opcode_q, opcode_d;
  logic [BITS-1:0]         result_q, result_d;
  logic                    invalid_q, invalid_d;
  logic                    start_q, start_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= WAIT_OPERAND;
      idx_q      <= '0;
      cnt_q      <= '0;
      operands_q <= '0;
      opcode_q   <= '0;
      result_q   <= '0;
      invalid_q  <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      operands_q <= operands_d;
      opcode_q   <= opcode_d;
      result_q   <= result_d;
      invalid_q  <= invalid_d;
      start_q    <= start_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    operands_d = operands_q;
    opcode_d   = opcode_q;
    result_d   = result_q;
    invalid_d  = invalid_q;
    start_d    = 1'b0;
    num_salida = '0;
    anodoIn    = 8'hFF;
    op_number  = 4'(NUM_OPS + 2);
    LED_RG     = 2'b00;

    case (state_q)
      WAIT_OPERAND: begin
        num_salida = SW;
        anodoIn    = ~DIG_MASK;
        op_number  = 4'(idx_q) + 4'd1;
        if (next) begin
          operands_d[idx_q*BITS +: BITS] = SW;
          if (idx_q == LAST_IDX) state_d = WAIT_OPCODE;
          else                   idx_d   = idx_q + 1'b1;
        end else if (undo && idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end
      end
      WAIT_OPCODE: begin
        num_salida = BITS'(SW[OP_W-1:0]);
        anodoIn    = ~8'b1000_0000;
        op_number  = 4'(NUM_OPS + 1);
        if (next) begin
          opcode_d = SW[OP_W-1:0];
          cnt_d    = '0;
          start_d  = 1'b1;
          state_d  = COMPUTE;
        end else if (undo) begin
          idx_d   = LAST_IDX;
          state_d = WAIT_OPERAND;
        end
      end
      COMPUTE: begin
        // undo outranks a coincident alu_done so an aborted result is never shown
        if (undo) begin
          state_d = WAIT_OPCODE;
        end else if (alu_done) begin
          result_d  = alu_result;
          invalid_d = alu_invalid;
          state_d   = SHOW_RESULT;
        end else if (cnt_q == LAST_CNT) begin
          result_d  = '0;
          invalid_d = 1'b1;
          state_d   = SHOW_RESULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHOW_RESULT: begin
        num_salida = result_q;
        anodoIn    = ~DIG_MASK;
        LED_RG     = invalid_q ? 2'b10 : 2'b01;
        if (next) begin
          operands_d = '0;
          opcode_d   = '0;
          idx_d      = '0;
          state_d    = WAIT_OPERAND;
        end else if (undo) begin
          state_d = WAIT_OPCODE;
        end
      end
      default: state_d = WAIT_OPERAND;
    endcase
  end

  assign operands  = operands_q;
  assign opcode    = opcode_q;
  assign alu_start = start_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// tb/tb_calc_entry_fsm.sv - randomized self-checking bench for calc_entry_fsm
module tb_calc_entry_fsm;
  localparam int BITS = 8, NUM_OPS = 2, OP_W = 3, DIGITS = 3, TIMEOUT = 10;

  logic clk = 1'b0, rst = 1'b0, next = 1'b0, undo = 1'b0;
  logic alu_invalid = 1'b0, alu_done = 1'b0;
  logic [BITS-1:0] SW = '0, alu_result = '0;
  logic [NUM_OPS*BITS-1:0] operands;
  logic [OP_W-1:0] opcode;
  logic alu_start;
  logic [BITS-1:0] num_salida;
  logic [7:0] anodoIn;
  logic [3:0] op_number;
  logic [1:0] LED_RG;

  calc_entry_fsm #(.BITS(BITS), .NUM_OPS(NUM_OPS), .OP_W(OP_W), .DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .next(next), .undo(undo), .SW(SW),
    .alu_result(alu_result), .alu_invalid(alu_invalid), .alu_done(alu_done),
    .operands(operands), .opcode(opcode), .alu_start(alu_start),
    .num_salida(num_salida), .anodoIn(anodoIn), .op_number(op_number), .LED_RG(LED_RG)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, comparisons = 0;

  // reference: mode 0=entering operand, 1=entering opcode, 2=computing, 3=showing
  int m_mode, m_idx, m_age;
  logic [BITS-1:0] m_ops [NUM_OPS];
  logic [OP_W-1:0] m_opc;
  logic [BITS-1:0] m_res;
  logic m_inv, m_start;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    comparisons++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_age = 0;
    for (int k = 0; k < NUM_OPS; k++) m_ops[k] = '0;
    m_opc = '0; m_res = '0; m_inv = 1'b0; m_start = 1'b0;
  endtask

  task automatic model_step(input logic n, input logic u, input logic [BITS-1:0] sw,
                            input logic d, input logic [BITS-1:0] r, input logic inv);
    m_start = 1'b0;
    case (m_mode)
      0: if (n) begin
           m_ops[m_idx] = sw;
           if (m_idx == NUM_OPS - 1) m_mode = 1; else m_idx++;
         end else if (u && m_idx > 0) m_idx--;
      1: if (n) begin
           m_opc = sw[OP_W-1:0]; m_mode = 2; m_age = 0; m_start = 1'b1;
         end else if (u) begin
           m_mode = 0; m_idx = NUM_OPS - 1;
         end
      2: if (u) m_mode = 1;
         else if (d) begin
           m_res = r; m_inv = inv; m_mode = 3;
         end else begin
           m_age++;
           if (m_age == TIMEOUT) begin m_res = '0; m_inv = 1'b1; m_mode = 3; end
         end
      default: if (n) begin
           for (int k = 0; k < NUM_OPS; k++) m_ops[k] = '0;
           m_opc = '0; m_idx = 0; m_mode = 0;
         end else if (u) m_mode = 1;
    endcase
  endtask

  task automatic check_model();
    logic [NUM_OPS*BITS-1:0] flat;
    logic [BITS-1:0] e_num;
    logic [7:0] e_an;
    int e_opn;
    for (int k = 0; k < NUM_OPS; k++) flat[k*BITS +: BITS] = m_ops[k];
    case (m_mode)
      0: begin e_num = SW;                      e_an = 8'hF8; e_opn = m_idx + 1;   end
      1: begin e_num = {5'b0, SW[OP_W-1:0]};    e_an = 8'h7F; e_opn = NUM_OPS + 1; end
      2: begin e_num = '0;                      e_an = 8'hFF; e_opn = NUM_OPS + 2; end
      default: begin e_num = m_res;             e_an = 8'hF8; e_opn = NUM_OPS + 2; end
    endcase
    chk("num_salida", 32'(num_salida), 32'(e_num));
    chk("anodoIn", 32'(anodoIn), 32'(e_an));
    chk("op_number", 32'(op_number), 32'(e_opn));
    chk("LED_RG", 32'(LED_RG), (m_mode == 3) ? (m_inv ? 32'd2 : 32'd1) : 32'd0);
    chk("operands", 32'(operands), 32'(flat));
    chk("opcode", 32'(opcode), 32'(m_opc));
    chk("alu_start", 32'(alu_start), 32'(m_start));
  endtask

  task automatic step(input logic n, input logic u, input logic [BITS-1:0] sw,
                      input logic d = 1'b0, input logic [BITS-1:0] r = '0, input logic inv = 1'b0);
    next = n; undo = u; SW = sw; alu_done = d; alu_result = r; alu_invalid = inv;
    @(posedge clk); #1;
    model_step(n, u, sw, d, r, inv);
    vectors++;
    check_model();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_op_number", 32'(op_number), 32'd1);
    chk("reset_operands", 32'(operands), 32'd0);
    chk("reset_alu_start", 32'(alu_start), 32'd0);
    chk("reset_led", 32'(LED_RG), 32'd0);
    chk("reset_anodo", 32'(anodoIn), 32'hF8);
    rst = 1'b1;

    step(1, 0, 8'h12); chk("seq_opn2", 32'(op_number), 32'd2);
    step(1, 0, 8'h34); chk("seq_opn3", 32'(op_number), 32'd3);
    step(1, 0, 8'h03);
    chk("seq_operands", 32'(operands), 32'h3412);
    chk("seq_opcode", 32'(opcode), 32'd3);
    chk("seq_start_hi", 32'(alu_start), 32'd1);
    chk("seq_opn4", 32'(op_number), 32'd4);
    step(0, 0, 8'h03); chk("seq_start_lo", 32'(alu_start), 32'd0);
    repeat (3) step(0, 0, 8'h03);
    step(0, 0, 8'h03, 1, 8'h46, 0);
    chk("valid_result", 32'(num_salida), 32'h46);
    chk("valid_led", 32'(LED_RG), 32'd1);
    step(0, 1, 8'h03);
    step(1, 0, 8'h03);
    step(0, 0, 8'h03, 1, 8'h46, 1);
    chk("invalid_led", 32'(LED_RG), 32'd2);

    // timeout: no alu_done, result must appear TIMEOUT cycles after entering COMPUTE
    step(0, 1, 8'h03);
    step(1, 0, 8'h03);
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      step(0, 0, 8'h03);
      if (LED_RG != 2'b00) begin k = c; break; end
    end
    chk("timeout_cycles", k, 32'd10);
    chk("timeout_result", 32'(num_salida), 32'd0);
    chk("timeout_led", 32'(LED_RG), 32'd2);

    step(1, 0, 8'h00); chk("cleared_operands", 32'(operands), 32'd0);
    step(1, 1, 8'h5A);
    chk("both_opn", 32'(op_number), 32'd2);
    chk("both_latch", 32'(operands), 32'h005A);
    step(0, 1, 8'h00); chk("undo_opn", 32'(op_number), 32'd1);
    step(0, 1, 8'h00);
    chk("undo_idx0_opn", 32'(op_number), 32'd1);
    chk("undo_idx0_keep", 32'(operands), 32'h005A);

    step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h05);
    step(0, 0, 8'h05);
    step(0, 1, 8'h05, 1, 8'h99, 0);
    chk("abort_opn", 32'(op_number), 32'd3);
    chk("abort_led", 32'(LED_RG), 32'd0);
    step(0, 0, 8'h05); chk("abort_no_start", 32'(alu_start), 32'd0);

    step(1, 0, 8'h05);
    step(0, 0, 8'h05); step(0, 0, 8'h05);
    #1 rst = 1'b0;
    #1;
    chk("arst_opn", 32'(op_number), 32'd1);
    chk("arst_operands", 32'(operands), 32'd0);
    chk("arst_opcode", 32'(opcode), 32'd0);
    chk("arst_start", 32'(alu_start), 32'd0);
    chk("arst_led", 32'(LED_RG), 32'd0);
    chk("arst_num", 32'(num_salida), 32'h05);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      logic n, u;
      n = ($urandom_range(0, 99) < 30);
      u = ($urandom_range(0, 99) < ((m_mode == 2) ? 8 : 20));
      step(n, u, 8'($urandom), ($urandom_range(0, 5) == 0), 8'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/calc_entry_fsm.md
Name: calc_entry_fsm

Overview:
- Parametrised successor to the operand-entry controller for the switch-driven calculator.
- Sequences entry of NUM_OPS operands plus one opcode from the switches. Latches each value into registers, then starts the ALU with a start/done handshake, guarded by a timeout.
- Shows the result with a red/green validity LED.
- Sits between the debounced button pulses and switches on one side and the ALU and 7-segment driver on the other.

Parameters:
- BITS, 8: operand/result width.
- NUM_OPS, 2: number of operands entered, 1..8.
- OP_W, 3: opcode width, taken from SW[OP_W-1:0].
- DIGITS, 3: display digits used for values, 1..7; drives anodes 0..DIGITS-1.
- TIMEOUT, 255: cycles to wait for alu_done before forcing an invalid result, >=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- next  in  1  one-cycle pulse, advance/confirm (centre button).
- undo  in  1  one-cycle pulse, step back (down button).
- SW  in  BITS  switch value.
- alu_result  in  BITS  ALU result, valid when alu_done=1.
- alu_invalid  in  1  ALU error flag, valid when alu_done=1.
- alu_done  in  1  ALU completion pulse.
- operands  out  NUM_OPS*BITS  latched operands; operand k occupies bits [k*BITS +: BITS].
- opcode  out  OP_W  latched opcode.
- alu_start  out  1  one-cycle start pulse, registered.
- num_salida  out  BITS  value to display.
- anodoIn  out  8  active-low digit enable mask.
- op_number  out  4  current step number, 1-based.
- LED_RG  out  2  2'b10 red = invalid, 2'b01 green = valid, 2'b00 off.

Behaviour:
States: WAIT_OPERAND (with index idx, 0..NUM_OPS-1), WAIT_OPCODE, COMPUTE, SHOW_RESULT.

Reset (rst=0, asynchronous):
- state=WAIT_OPERAND, idx=0.
- operands, opcode, latched result, latched invalid and timeout counter all cleared to 0.
- alu_start=0.

Priority: next beats undo when both are asserted in the same cycle.

WAIT_OPERAND:
- On next: write SW into operand idx; idx increments, or go to WAIT_OPCODE when idx=NUM_OPS-1.
- On undo: idx decrements; at idx=0, stay put. The previously latched operand is retained and is overwritten on the next confirm.

WAIT_OPCODE:
- On next: latch SW[OP_W-1:0] into opcode, enter COMPUTE, and assert alu_start for exactly the first COMPUTE cycle.
- On undo: go to WAIT_OPERAND with idx=NUM_OPS-1.

COMPUTE:
- Timeout counter starts at 0 on entry and increments each cycle.
- On alu_done: latch alu_result and alu_invalid, go to SHOW_RESULT.
- Else if counter reaches TIMEOUT: latch result=0 and invalid=1, go to SHOW_RESULT.
- next is ignored.
- undo aborts to WAIT_OPCODE; alu_done arriving in that same cycle is discarded.

SHOW_RESULT:
- On next: clear operands and opcode, go to WAIT_OPERAND with idx=0.
- On undo: go to WAIT_OPCODE with the opcode kept.

Outputs (combinational from state, except alu_start):
- WAIT_OPERAND: num_salida=SW (live preview); anodoIn=~((1<<DIGITS)-1); op_number=idx+1.
- WAIT_OPCODE: num_salida=zero-extended SW[OP_W-1:0]; anodoIn=~8'b1000_0000; op_number=NUM_OPS+1.
- COMPUTE: num_salida=0; anodoIn=8'hFF (blank); op_number=NUM_OPS+2.
- SHOW_RESULT: num_salida=latched result; anodoIn=~((1<<DIGITS)-1); op_number=NUM_OPS+2.
- LED_RG: nonzero only in SHOW_RESULT.
- alu_start: never asserted outside the first COMPUTE cycle.

Test Plan:
- BITS=8, NUM_OPS=2: SW=0x12,next; SW=0x34,next; SW=3,next -> operands=0x3412, opcode=3, alu_start high 1 cycle, op_number 1→2→3→4.
- ALU returns done with result 0x46 and invalid=0 after 5 cycles -> SHOW_RESULT, num_salida=0x46, LED_RG=01. Repeat with invalid=1 -> LED_RG=10.
- TIMEOUT=10, alu_done never asserted -> SHOW_RESULT exactly 10 cycles after entering COMPUTE, num_salida=0, LED_RG=10.
- next and undo asserted together in WAIT_OPERAND idx=0 -> advances to idx=1 and latches SW. undo at idx=0 alone -> no change.
- undo in COMPUTE, simultaneous with alu_done -> WAIT_OPCODE, result not latched, alu_start not re-pulsed.
- rst pulsed low mid-COMPUTE -> all outputs at reset values immediately, op_number=1, operands=0.
